// File: rtl/hamming_enc_stage.sv
// Extended-Hamming (SECDED) encoder with a 2-stage elastic valid/ready pipeline.
// Optional macro ERR_INJECT_EN adds an inj_mask input that flips codeword bits for decoder testing.
module hamming_enc_stage #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_INFO_WIDTH-1:0]     data_in,
    input  logic [1:0]                    mod,
`ifdef ERR_INJECT_EN
    input  logic [MAX_CODEWORD_WIDTH-1:0] inj_mask,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [1:0]                    out_mod,
    output logic                          err_illegal_mod,
    output logic [CNT_WIDTH-1:0]          word_cnt
);

    typedef enum logic [1:0] {
        MODE_8   = 2'b00,
        MODE_16  = 2'b01,
        MODE_32  = 2'b10,
        MODE_BAD = 2'b11
    } mode_e;

    // Codeword position of info bit idx: the idx-th non-power-of-two in 3,5,6,7,9,...,31.
    function automatic logic [4:0] info_pos(input int idx);
        int          cnt;
        logic [4:0]  res;
        cnt = 0;
        res = '0;
        for (int p = 3; p < 32; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) res = p[4:0];
                cnt++;
            end
        end
        return res;
    endfunction

    function automatic logic [MAX_INFO_WIDTH-1:0] info_mask(input logic [1:0] m);
        logic [MAX_INFO_WIDTH-1:0] k;
        k = '0;
        case (mode_e'(m))
            MODE_8:  k[3:0]  = '1;
            MODE_16: k[10:0] = '1;
            MODE_32: k[25:0] = '1;
            default: k       = '0;
        endcase
        return k;
    endfunction

`ifdef ERR_INJECT_EN
    function automatic logic [MAX_CODEWORD_WIDTH-1:0] width_mask(input logic [1:0] m);
        logic [MAX_CODEWORD_WIDTH-1:0] w;
        w = '0;
        case (mode_e'(m))
            MODE_8:  w[7:0]  = '1;
            MODE_16: w[15:0] = '1;
            MODE_32: w[31:0] = '1;
            default: w       = '0;
        endcase
        return w;
    endfunction
`endif

    logic                          s1_valid;
    logic [MAX_INFO_WIDTH-1:0]     s1_info;
    logic [1:0]                    s1_mod;
    logic [4:0]                    s1_par;
`ifdef ERR_INJECT_EN
    logic [MAX_CODEWORD_WIDTH-1:0] s1_inj;
`endif

    logic                          s2_adv;
    logic                          s1_adv;
    logic                          accept;
    logic                          legal;
    logic [MAX_INFO_WIDTH-1:0]     info_m;
    logic [4:0]                    par_lo;
    logic [MAX_CODEWORD_WIDTH-1:0] cw;
    logic                          ovr;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && in_ready;
    assign legal    = (mode_e'(mod) != MODE_BAD);

    // S1 combinational: mask unused MSBs, then fold each set info bit's position into p[0..4].
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        info_m = data_in & info_mask(mod);
        par_lo = '0;
        for (int i = 0; i < MAX_INFO_WIDTH; i++) begin
            if (info_m[i]) par_lo = par_lo ^ info_pos(i);
        end
    end

    // S2 combinational: overall parity plus codeword assembly; unused upper bits stay zero.
    always_comb begin
        cw  = '0;
        ovr = ^s1_info;
        case (mode_e'(s1_mod))
            MODE_8:  cw[7:0]  = {s1_info[3:0],  ovr ^ (^s1_par[2:0]), s1_par[2:0]};
            MODE_16: cw[15:0] = {s1_info[10:0], ovr ^ (^s1_par[3:0]), s1_par[3:0]};
            default: cw[31:0] = {s1_info[25:0], ovr ^ (^s1_par[4:0]), s1_par[4:0]};
        endcase
`ifdef ERR_INJECT_EN
        cw = cw ^ (s1_inj & width_mask(s1_mod));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid        <= 1'b0;
            s1_info         <= '0;
            s1_mod          <= '0;
            s1_par          <= '0;
`ifdef ERR_INJECT_EN
            s1_inj          <= '0;
`endif
            err_illegal_mod <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            err_illegal_mod <= accept && !legal;
            if (s1_adv) begin
                s1_valid <= accept && legal;
                if (accept && legal) begin
                    s1_info <= info_m;
                    s1_mod  <= mod;
                    s1_par  <= par_lo;
`ifdef ERR_INJECT_EN
                    s1_inj  <= inj_mask;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            out_mod   <= '0;
            word_cnt  <= '0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    data_out <= cw;
                    out_mod  <= s1_mod;
                end
            end
            if (out_valid && out_ready && (word_cnt != '1)) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_enc_stage.sv
// Directed self-checking bench for hamming_enc_stage; word_cnt is narrowed to 4 bits so saturation is reachable.
module tb_hamming_enc_stage;

    localparam int CWW = 32;
    localparam int IW  = 26;
    localparam int CN  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [IW-1:0]  data_in;
    logic [1:0]     mod;
    logic           out_valid;
    logic           out_ready;
    logic [CWW-1:0] data_out;
    logic [1:0]     out_mod;
    logic           err_illegal_mod;
    logic [CN-1:0]  word_cnt;
`ifdef ERR_INJECT_EN
    logic [CWW-1:0] inj_mask;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hamming_enc_stage #(
        .MAX_CODEWORD_WIDTH(CWW),
        .MAX_INFO_WIDTH(IW),
        .CNT_WIDTH(CN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_in(data_in),
        .mod(mod),
`ifdef ERR_INJECT_EN
        .inj_mask(inj_mask),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out(data_out),
        .out_mod(out_mod),
        .err_illegal_mod(err_illegal_mod),
        .word_cnt(word_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle on the following falling edge for sampling and driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [IW-1:0] d);
        in_valid = v;
        mod      = m;
        data_in  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, '0);
`ifdef ERR_INJECT_EN
        inj_mask  = '0;
`endif
        tick();
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data_out", data_out, 32'h0);
        check("rst_out_mod", {30'b0, out_mod}, 32'd0);
        check("rst_err", {31'b0, err_illegal_mod}, 32'd0);
        check("rst_cnt", {28'b0, word_cnt}, 32'd0);
        rst = 1'b0;
        tick();

        // Single 8-bit word, latency 2 edges
        drive(1'b1, 2'b00, 26'h000_000B);
        check("t1_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 2'b00, '0);
        check("t1_lat1_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check("t1_valid", {31'b0, out_valid}, 32'd1);
        check("t1_data", data_out, 32'h0000_00B1);
        check("t1_mod", {30'b0, out_mod}, 32'd0);
        tick();
        check("t1_cnt", {28'b0, word_cnt}, 32'd1);
        check("t1_idle", {31'b0, out_valid}, 32'd0);

        // Back-to-back 16, 32, and 8-bit with junk MSBs
        drive(1'b1, 2'b01, 26'h000_07FF);
        tick();
        drive(1'b1, 2'b10, 26'h000_0001);
        check("t2_rdy_b", {31'b0, in_ready}, 32'd1);
        tick();
        drive(1'b1, 2'b00, 26'h3FF_FFF7);
        check("t2_rdy_c", {31'b0, in_ready}, 32'd1);
        check("t2_a_valid", {31'b0, out_valid}, 32'd1);
        check("t2_a_data", data_out, 32'h0000_FFFF);
        check("t2_a_mod", {30'b0, out_mod}, 32'd1);
        tick();
        drive(1'b0, 2'b00, '0);
        check("t2_b_valid", {31'b0, out_valid}, 32'd1);
        check("t2_b_data", data_out, 32'h0000_0063);
        check("t2_b_mod", {30'b0, out_mod}, 32'd2);
        tick();
        check("t2_c_valid", {31'b0, out_valid}, 32'd1);
        check("t2_c_data", data_out, 32'h0000_0078);
        check("t2_c_mod", {30'b0, out_mod}, 32'd0);
        tick();
        check("t2_idle", {31'b0, out_valid}, 32'd0);
        check("t2_cnt", {28'b0, word_cnt}, 32'd4);

        // Backpressure: three words offered, two fit
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 26'h000_000B);
        check("t3_rdy_w1", {31'b0, in_ready}, 32'd1);
        tick();
        drive(1'b1, 2'b01, 26'h000_07FF);
        check("t3_rdy_w2", {31'b0, in_ready}, 32'd1);
        tick();
        drive(1'b1, 2'b10, 26'h000_0001);
        check("t3_rdy_w3_blocked", {31'b0, in_ready}, 32'd0);
        check("t3_stall_valid", {31'b0, out_valid}, 32'd1);
        check("t3_stall_data0", data_out, 32'h0000_00B1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold_data", data_out, 32'h0000_00B1);
            check("t3_hold_mod", {30'b0, out_mod}, 32'd0);
            check("t3_hold_rdy", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("t3_release_rdy", {31'b0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 2'b00, '0);
        check("t3_w2_data", data_out, 32'h0000_FFFF);
        check("t3_cnt5", {28'b0, word_cnt}, 32'd5);
        tick();
        check("t3_w3_data", data_out, 32'h0000_0063);
        check("t3_cnt6", {28'b0, word_cnt}, 32'd6);
        tick();
        check("t3_idle", {31'b0, out_valid}, 32'd0);
        check("t3_cnt7", {28'b0, word_cnt}, 32'd7);

        // Illegal mode dropped with a one-cycle error pulse
        drive(1'b1, 2'b11, 26'h3FF_FFFF);
        check("t4_rdy", {31'b0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 2'b00, '0);
        check("t4_err_pulse", {31'b0, err_illegal_mod}, 32'd1);
        check("t4_no_valid1", {31'b0, out_valid}, 32'd0);
        tick();
        check("t4_err_clear", {31'b0, err_illegal_mod}, 32'd0);
        check("t4_no_valid2", {31'b0, out_valid}, 32'd0);
        tick();
        check("t4_no_valid3", {31'b0, out_valid}, 32'd0);
        check("t4_cnt", {28'b0, word_cnt}, 32'd7);

        // Asynchronous reset with two words in flight
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 26'h000_000B);
        tick();
        drive(1'b1, 2'b01, 26'h000_07FF);
        tick();
        drive(1'b0, 2'b00, '0);
        check("t5_pre_valid", {31'b0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_valid", {31'b0, out_valid}, 32'd0);
        check("t5_async_data", data_out, 32'h0);
        check("t5_async_cnt", {28'b0, word_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_no_stale", {31'b0, out_valid}, 32'd0);
        end

        // Continuous stream: full throughput and counter saturation
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 2'b00, 26'h000_000B);
            tick();
            if (i >= 1) begin
                check("t6_stream_valid", {31'b0, out_valid}, 32'd1);
            end
        end
        drive(1'b0, 2'b00, '0);
        tick();
        check("t6_last_valid", {31'b0, out_valid}, 32'd1);
        check("t6_last_data", data_out, 32'h0000_00B1);
        tick();
        check("t6_idle", {31'b0, out_valid}, 32'd0);
        check("t6_cnt_sat", {28'b0, word_cnt}, 32'd15);

`ifdef ERR_INJECT_EN
        // Injection is limited to the active codeword width
        inj_mask = 32'h0000_0101;
        drive(1'b1, 2'b00, 26'h000_000B);
        tick();
        drive(1'b0, 2'b00, '0);
        inj_mask = '0;
        tick();
        check("t7_inj_valid", {31'b0, out_valid}, 32'd1);
        check("t7_inj_data", data_out, 32'h0000_00B0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
